sp_ram_param: RTL
=================

Name: sp_ram_param

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 16x8 single-port RAM.
- Adds:
  - configurable width, depth and read latency
  - byte-enable writes
  - a valid/ready request handshake with a read-valid strobe
  - selectable write-port read-back mode
  - a hardware memory-initialisation sweep after reset or on command
- Sits behind register-file / buffer controllers as the generic on-chip storage primitive.

Parameters:
- DATA_W, 8, word width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_MODE, 0, read-back on write: 0 = NO_CHANGE, 1 = WRITE_FIRST, 2 = READ_FIRST.
- INIT_VAL, 0, DATA_W-bit value written to every word during initialisation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  one-cycle pulse; restarts the initialisation sweep
- req_valid  in  1  request present
- req_ready  out  1  RAM can accept a request (low while busy)
- we  in  1  1 = write, 0 = read; qualified by handshake
- be  in  DATA_W/8  byte enables for writes; ignored on reads
- addr  in  ADDR_W  word address
- datain  in  DATA_W  write data
- dataout  out  DATA_W  read data (registered)
- rd_valid  out  1  one-cycle strobe: dataout is new this cycle
- busy  out  1  initialisation sweep in progress

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to INIT; init_ptr=0.
  - dataout=0, rd_valid=0, busy=1, req_ready=0, latency pipeline cleared.
  - Memory array itself is not reset; it is cleared by the sweep.
- FSM, two states:
  - INIT: writes INIT_VAL to mem[init_ptr] every cycle and increments init_ptr. When init_ptr == DEPTH-1 is written, go to RUN the next edge. Sweep takes exactly DEPTH cycles after rst deasserts.
  - RUN: busy=0, req_ready=1.
  - clr=1 in RUN: go to INIT with init_ptr=0. Any request presented in that same cycle is dropped (req_ready already low combinationally when clr=1).
  - clr=1 in INIT: restart at init_ptr=0.
  - rst asserted mid-sweep or mid-read: immediate return to INIT; pending reads are discarded, with no rd_valid.
- Handshake:
  - A request is accepted at a rising edge where req_valid & req_ready.
  - req_ready = (state==RUN) & ~clr.
  - Back-to-back requests are legal every cycle; there is no backpressure on the read side.
- Write accepted at edge k:
  - For each byte i with be[i]=1, mem[addr][8i+7:8i] = datain byte i.
  - be all zero means no memory change, but a request is still consumed.
- Read accepted at edge k:
  - RD_LAT=1: dataout = mem[addr] and rd_valid=1 after edge k, for one cycle.
  - RD_LAT=2: both appear after edge k+1.
  - dataout holds its last value while rd_valid=0.
- Write read-back, per WR_MODE:
  - 0: no rd_valid; dataout unchanged.
  - 1: rd_valid pulses with the post-write merged word.
  - 2: rd_valid pulses with the pre-write word.
  - Latency is the same as for reads.
- Ordering:
  - Results return in acceptance order.
  - A read accepted the cycle after a write to the same address returns the written data (no stale read).
- Address: full ADDR_W range is valid; no wrap or error logic is needed because DEPTH = 2**ADDR_W.

Decomposition:
- Package sp_ram_pkg:
  - WR_MODE encodings NO_CHANGE / WRITE_FIRST / READ_FIRST
  - FSM state enum INIT / RUN
  - function computing byte-lane count DATA_W/8
- One sub-module, sp_ram_core: the raw byte-enabled storage array with a registered read port, containing no control logic.
- Top level holds the FSM, init sweep, handshake and the RD_LAT / rd_valid pipeline.

Test Plan:
- Reset with defaults, release rst → busy=1 for exactly 16 cycles, then req_ready=1. Read all 16 addresses → each returns 0x00 with rd_valid one cycle after acceptance.
- Write 0xA5 to addr 3, then read addr 3 on the next cycle (RD_LAT=1) → dataout=0xA5, rd_valid=1 exactly one cycle after the read is accepted.
- DATA_W=32, mem[5]=0x11223344. Write datain=0xAABBCCDD, be=4'b0101 → subsequent read of addr 5 returns 0x11BB33DD.
- RD_LAT=2, WR_MODE=2: mem[7]=0x3C, then write 0x55 to addr 7 → rd_valid two cycles later with dataout=0x3C; next read returns 0x55.
- Pulse clr after writing 0xFF to addr 9 → busy=1 for 16 cycles and requests ignored. After the sweep, addr 9 reads INIT_VAL=0x00.
- Assert rst mid-sweep (init_ptr=8) and also with a read in flight (RD_LAT=2) → no rd_valid, dataout=0 immediately. Sweep restarts, busy lasts a full 16 cycles after release.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : sp_ram_pkg                                                   |
// | Description : Shared encodings, FSM state type and lane helper for sp_ram. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package sp_ram_pkg;

    localparam logic [1:0] C_WR_NO_CHANGE   = 2'd0;
    localparam logic [1:0] C_WR_WRITE_FIRST = 2'd1;
    localparam logic [1:0] C_WR_READ_FIRST  = 2'd2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sp_ram_param_if.sv
// +----------------------------------------------------------------------------+
// | Module      : sp_ram_param_if                                              |
// | Description : Request / response bundle between a controller and the RAM. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sp_ram_param_if
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);

    logic                            clr;
    logic                            req_valid;
    logic                            req_ready;
    logic                            we;
    logic [lane_count(DATA_W)-1:0]   be;
    logic [ADDR_W-1:0]               addr;
    logic [DATA_W-1:0]               datain;
    logic [DATA_W-1:0]               dataout;
    logic                            rd_valid;
    logic                            busy;

    modport master (
        output clr, req_valid, we, be, addr, datain,
        input  req_ready, dataout, rd_valid, busy
    );

    modport slave (
        input  clr, req_valid, we, be, addr, datain,
        output req_ready, dataout, rd_valid, busy
    );

endinterface

`default_nettype wire

// File: rtl/sp_ram_core.sv
// +----------------------------------------------------------------------------+
// | Module      : sp_ram_core                                                  |
// | Description : Byte-enabled storage array with a registered read port.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sp_ram_core
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  wire logic                            clk,
    input  wire logic                            we,
    input  wire logic [lane_count(DATA_W)-1:0]   be,
    input  wire logic                            re,
    input  wire logic [ADDR_W-1:0]               addr,
    input  wire logic [DATA_W-1:0]               wdata,
    output      logic [DATA_W-1:0]               rdata
);

    localparam int C_BE_W  = lane_count(DATA_W);
    localparam int C_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [C_DEPTH];

    // Read samples the array before this edge's write lands, so a same-cycle
    // write/read returns the old word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < C_BE_W; i++) begin
            if (we && be[i]) begin
                r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sp_ram_param.sv
// +----------------------------------------------------------------------------+
// | Module      : sp_ram_param                                                 |
// | Description : Parametrised single-port RAM with init sweep and handshake. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sp_ram_param
    import sp_ram_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               ADDR_W   = 4,
    parameter int               RD_LAT   = 1,
    parameter logic [1:0]       WR_MODE  = C_WR_NO_CHANGE,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input wire logic      clk,
    input wire logic      rst,
    sp_ram_param_if.slave bus
);

    localparam int                C_BE_W     = lane_count(DATA_W);
    localparam logic [ADDR_W-1:0] C_LAST_PTR = '1;
    localparam bit                C_RD_BACK  = (WR_MODE != C_WR_NO_CHANGE);
    localparam bit                C_MERGE    = (WR_MODE == C_WR_WRITE_FIRST);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_init_ptr;
    logic [ADDR_W-1:0]   w_init_ptr_nxt;
    logic                w_init;

    logic                w_accept;
    logic                w_wr_req;
    logic                w_rd_req;
    logic                w_pipe_in;

    logic                w_core_we;
    logic [C_BE_W-1:0]   w_core_be;
    logic [ADDR_W-1:0]   w_core_addr;
    logic [DATA_W-1:0]   w_core_wdata;
    logic [DATA_W-1:0]   w_core_rdata;

    logic                r_s1_valid;
    logic                r_s1_merge;
    logic [C_BE_W-1:0]   r_s1_be;
    logic [DATA_W-1:0]   r_s1_wdata;
    logic [DATA_W-1:0]   w_lane_mask;
    logic [DATA_W-1:0]   w_s1_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_ptr <= w_init_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        case (r_state)
            ST_INIT: begin
                if (bus.clr) begin
                    w_init_ptr_nxt = '0;
                end else if (r_init_ptr == C_LAST_PTR) begin
                    w_state_nxt    = ST_RUN;
                    w_init_ptr_nxt = '0;
                end else begin
                    w_init_ptr_nxt = r_init_ptr + 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.clr) begin
                    w_state_nxt    = ST_INIT;
                    w_init_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_INIT;
                w_init_ptr_nxt = '0;
            end
        endcase
    end

    assign w_init        = (r_state == ST_INIT);
    assign bus.busy      = w_init;
    assign bus.req_ready = (r_state == ST_RUN) & ~bus.clr;

    assign w_accept  = bus.req_valid & bus.req_ready;
    assign w_wr_req  = w_accept & bus.we;
    assign w_rd_req  = w_accept & ~bus.we;
    assign w_pipe_in = w_rd_req | (w_wr_req & C_RD_BACK);

    // The sweep owns the array while busy; requests are never accepted then.
    assign w_core_we    = w_init | w_wr_req;
    assign w_core_be    = w_init ? {C_BE_W{1'b1}} : bus.be;
    assign w_core_addr  = w_init ? r_init_ptr : bus.addr;
    assign w_core_wdata = w_init ? INIT_VAL : bus.datain;

    sp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (w_core_we),
        .be    (w_core_be),
        .re    (w_accept),
        .addr  (w_core_addr),
        .wdata (w_core_wdata),
        .rdata (w_core_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_merge <= 1'b0;
            r_s1_be    <= '0;
            r_s1_wdata <= '0;
        end else begin
            r_s1_valid <= w_pipe_in;
            r_s1_merge <= w_wr_req & C_MERGE;
            if (w_wr_req) begin
                r_s1_be    <= bus.be;
                r_s1_wdata <= bus.datain;
            end
        end
    end

    // Write-first read-back rebuilds the post-write word from the old word
    // the core returned plus the enabled lanes of the captured write data.
    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < C_BE_W; i++) begin
            w_lane_mask[8*i +: 8] = {8{r_s1_be[i]}};
        end
    end

    assign w_s1_word = r_s1_merge ? ((w_core_rdata & ~w_lane_mask) | (r_s1_wdata & w_lane_mask))
                                  : w_core_rdata;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s2_valid;
            logic [DATA_W-1:0] r_dout;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s2_valid <= 1'b0;
                    r_dout     <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_dout <= w_s1_word;
                    end
                end
            end

            assign bus.rd_valid = r_s2_valid;
            assign bus.dataout  = r_dout;
        end else begin : g_lat1
            logic [DATA_W-1:0] r_hold;
            logic [DATA_W-1:0] w_dout;

            // Core output register supplies the new word; r_hold keeps it
            // stable once the strobe drops.
            assign w_dout = r_s1_valid ? w_s1_word : r_hold;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hold <= '0;
                end else begin
                    r_hold <= w_dout;
                end
            end

            assign bus.rd_valid = r_s1_valid;
            assign bus.dataout  = w_dout;
        end
    endgenerate

endmodule

`default_nettype wire
